// File: rtl/gamma_argument_decoder_pkg.sv
// Shared definitions for the Elias-gamma argument decoder: FSM state
// encoding and a constant-evaluable ceiling log2 helper.
package gamma_argument_decoder_pkg;

  typedef enum logic [1:0] {
    ST_PREFIX = 2'd0,
    ST_SUFFIX = 2'd1,
    ST_HOLD   = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

  // Ceiling log2, usable in parameter defaults.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gamma_argument_decoder_tzc.sv
// Trailing-zero counter for the upstream window. Counts zeros below the
// lowest set bit; count reads 0 and all_zero is raised when no bit is set.
module trailing_zero_count #(
  parameter int WIDTH_OUT      = 8,
  parameter int LOG2_WIDTH_OUT = 3
) (
  input  logic [WIDTH_OUT-1:0]    vec,
  output logic [LOG2_WIDTH_OUT:0] count,
  output logic                    all_zero
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    count    = '0;
    all_zero = ~|vec;
    for (int i = WIDTH_OUT - 1; i >= 0; i--) begin
      if (vec[i]) count = (LOG2_WIDTH_OUT + 1)'(i);
    end
  end

endmodule

// File: rtl/gamma_argument_decoder.sv
// Elias-gamma argument decoder. Peeks at the upstream bit window (LSB is the
// next unconsumed bit), pops the prefix and suffix of each code in two
// phases, and holds the decoded value on a valid/ack port until accepted.
// An all-zero window while looking for a prefix is unrecoverable and locks
// the block in ERROR until reset.
module gamma_argument_decoder
  import gamma_argument_decoder_pkg::*;
#(
  parameter int WIDTH_OUT      = 8,
  parameter int VALUE_WIDTH    = 8,
  parameter int LOG2_WIDTH_OUT = log2(WIDTH_OUT - 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH_OUT-1:0]      win_q,
  input  logic                      win_ready,
  output logic [LOG2_WIDTH_OUT:0]   win_pop,
  output logic [VALUE_WIDTH-1:0]    value,
  output logic                      value_valid,
  input  logic                      value_ack,
  output logic                      error
);

  state_t                   state_q, state_d;
  logic [LOG2_WIDTH_OUT:0]  k_q, k_d;
  logic [VALUE_WIDTH-1:0]   value_q, value_d;
  logic                     valid_q, error_q;

  logic [LOG2_WIDTH_OUT:0]  tz_count;
  logic                     tz_all_zero;
  logic [VALUE_WIDTH-1:0]   lead_bit;
  logic [VALUE_WIDTH-1:0]   suffix_value;

  trailing_zero_count #(
    .WIDTH_OUT      (WIDTH_OUT),
    .LOG2_WIDTH_OUT (LOG2_WIDTH_OUT)
  ) u_tzc (
    .vec      (win_q),
    .count    (tz_count),
    .all_zero (tz_all_zero)
  );

  // Implicit leading one at bit k plus the k suffix bits now at the window LSBs.
  assign lead_bit     = VALUE_WIDTH'(1) << k_q;
  assign suffix_value = lead_bit | (VALUE_WIDTH'(win_q) & (lead_bit - VALUE_WIDTH'(1)));

  // Next-state, latched k, next value and the Mealy pop request.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    value_d = value_q;
    win_pop = '0;
    case (state_q)
      ST_PREFIX: begin
        if (win_ready) begin
          if (tz_all_zero) begin
            state_d = ST_ERROR;
          end else begin
            win_pop = tz_count + (LOG2_WIDTH_OUT + 1)'(1);
            k_d     = tz_count;
            if (tz_count == '0) begin
              value_d = VALUE_WIDTH'(1);
              state_d = ST_HOLD;
            end else begin
              state_d = ST_SUFFIX;
            end
          end
        end
      end
      ST_SUFFIX: begin
        if (win_ready) begin
          win_pop = k_q;
          value_d = suffix_value;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (value_ack) state_d = ST_PREFIX;
      end
      default: ;
    endcase
  end

  // State and output registers; valid/error mirror the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_PREFIX;
      k_q     <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      value_q <= value_d;
      valid_q <= (state_d == ST_HOLD);
      error_q <= (state_d == ST_ERROR);
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign error       = error_q;

endmodule

// File: tb/tb_gamma_argument_decoder.sv
// Bench for gamma_argument_decoder: a bit-queue upstream model, a gamma
// encoder that feeds a scoreboard, directed latency/stall/error scenarios
// and a randomized stream with random upstream stalls and downstream ack.
module tb_gamma_argument_decoder;

  localparam int WO = 8;
  localparam int VW = 8;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [WO-1:0] win_q = '0;
  logic          win_ready = 1'b0;
  logic [LW:0]   win_pop;
  logic [VW-1:0] value;
  logic          value_valid;
  logic          value_ack = 1'b0;
  logic          error;

  gamma_argument_decoder #(
    .WIDTH_OUT      (WO),
    .VALUE_WIDTH    (VW),
    .LOG2_WIDTH_OUT (LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .win_q       (win_q),
    .win_ready   (win_ready),
    .win_pop     (win_pop),
    .value       (value),
    .value_valid (value_valid),
    .value_ack   (value_ack),
    .error       (error)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  bit   bitq[$];
  int   expq[$];
  bit   gate = 1'b0;
  bit   ack_next = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Gamma-encode v LSB-first into the upstream stream and expect it back.
  task automatic push_value(input int v);
    int k;
    k = 0;
    for (int i = 0; i < 31; i++) if ((v >> i) & 1) k = i;
    for (int i = 0; i < k; i++) bitq.push_back(1'b0);
    bitq.push_back(1'b1);
    for (int i = 0; i < k; i++) bitq.push_back(bit'((v >> i) & 1));
    expq.push_back(v);
  endtask

  // One cycle: present upstream window, read the pop request, apply it.
  task automatic step(output int pop);
    logic [WO-1:0] wq;
    @(negedge clk);
    for (int i = 0; i < WO; i++) wq[i] = (i < bitq.size()) ? bitq[i] : 1'b0;
    win_q     = wq;
    win_ready = gate && (bitq.size() >= WO);
    value_ack = ack_next;
    #1;
    pop = int'(win_pop);
    if (!win_ready && pop != 0) chk("pop_without_ready", pop, 0);
    if (pop > bitq.size()) chk("pop_exceeds_window", pop, bitq.size());
    else for (int i = 0; i < pop; i++) void'(bitq.pop_front());
  endtask

  task automatic do_reset();
    int p;
    rst = 1'b0;
    gate = 1'b0;
    ack_next = 1'b0;
    bitq.delete();
    step(p);
    @(posedge clk);
    #1;
    rst = 1'b1;
    expq.delete();
    bitq.delete();
  endtask

  // Monitor: compare each accepted value against the scoreboard and check
  // that a pending value does not change under backpressure.
  initial begin
    bit            pv = 1'b0;
    bit            pa = 1'b0;
    logic [VW-1:0] pval = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pv = 1'b0;
        pa = 1'b0;
      end else begin
        if (value_valid && pv && !pa) chk("value_stable", int'(value), int'(pval));
        if (value_valid && value_ack) begin
          if (expq.size() == 0) chk("unexpected_value", int'(value), -1);
          else chk("scoreboard_value", int'(value), expq.pop_front());
          n_acc++;
        end
        pv   = value_valid;
        pa   = value_ack;
        pval = value;
      end
    end
  end

  initial begin
    int p;
    int target;
    int steps;

    // Reset state.
    do_reset();
    chk("rst_value", int'(value), 0);
    chk("rst_valid", int'(value_valid), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_pop", int'(win_pop), 0);

    // k=0: pop 1, value 1 one cycle later.
    for (int i = 0; i < 8; i++) push_value(1);
    gate = 1'b1;
    step(p); chk("k0_pop", p, 1); chk("k0_valid_early", int'(value_valid), 0);
    step(p); chk("k0_valid", int'(value_valid), 1); chk("k0_value", int'(value), 1);
    chk("k0_hold_pop", p, 0);
    ack_next = 1'b1;
    step(p);

    // Value 5: pop 3, pop 2, value 5.
    do_reset();
    push_value(5);
    for (int i = 0; i < 8; i++) push_value(1);
    gate = 1'b1;
    step(p); chk("v5_prefix_pop", p, 3);
    step(p); chk("v5_suffix_pop", p, 2); chk("v5_valid_early", int'(value_valid), 0);
    step(p); chk("v5_valid", int'(value_valid), 1); chk("v5_value", int'(value), 5);

    // Maximum prefix: pop 8, pop 7, value 255.
    do_reset();
    push_value(255);
    for (int i = 0; i < 8; i++) push_value(1);
    gate = 1'b1;
    step(p); chk("max_prefix_pop", p, 8);
    step(p); chk("max_suffix_pop", p, 7);
    step(p); chk("max_valid", int'(value_valid), 1); chk("max_value", int'(value), 255);

    // Stall in SUFFIX, then backpressure in HOLD.
    do_reset();
    push_value(5);
    for (int i = 0; i < 8; i++) push_value(1);
    gate = 1'b1;
    step(p); chk("stall_prefix_pop", p, 3);
    gate = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(p); chk("stall_pop", p, 0); chk("stall_valid", int'(value_valid), 0);
    end
    gate = 1'b1;
    step(p); chk("stall_resume_pop", p, 2);
    for (int i = 0; i < 4; i++) begin
      step(p);
      chk("bp_valid", int'(value_valid), 1);
      chk("bp_value", int'(value), 5);
      chk("bp_pop", p, 0);
    end
    ack_next = 1'b1;
    step(p); chk("bp_ack_pop", p, 0);
    step(p); chk("bp_next_prefix_pop", p, 1);

    // Randomized stream with random upstream stalls and random ack.
    do_reset();
    target = n_acc + 300;
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 7);
      push_value((1 << k) | int'($urandom_range(0, (1 << k) - 1)));
    end
    for (int i = 0; i < 8; i++) push_value(1);
    steps = 0;
    while (n_acc < target && steps < 20000) begin
      gate     = ($urandom_range(0, 9) < 8);
      ack_next = ($urandom_range(0, 9) < 7);
      step(p);
      steps++;
    end
    if (n_acc < target) chk("random_accept_count", n_acc, target);

    // Error on an all-zero window, then recovery by reset.
    do_reset();
    for (int i = 0; i < 8; i++) bitq.push_back(1'b0);
    gate = 1'b1;
    step(p); chk("err_pop", p, 0); chk("err_early", int'(error), 0);
    for (int i = 0; i < 4; i++) begin
      step(p);
      chk("err_sticky", int'(error), 1);
      chk("err_valid", int'(value_valid), 0);
      chk("err_pop_zero", p, 0);
    end
    chk("err_bits_kept", bitq.size(), 8);
    do_reset();
    chk("err_rst_error", int'(error), 0);
    chk("err_rst_valid", int'(value_valid), 0);
    chk("err_rst_value", int'(value), 0);
    for (int i = 0; i < 8; i++) push_value(1);
    gate = 1'b1;
    step(p); chk("err_rst_prefix_pop", p, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
